// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared state encoding, entry field layout and note mapping for tone_sequencer
package tone_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  localparam int NOTE_LSB = 0;
  localparam int NOTE_W = 4;
  localparam int DUR_LSB = 4;
  localparam int DUR_W = 12;
  localparam logic [3:0] NOTE_MAX = 4'd13;
  localparam logic [7:0] NOTE_REST = 8'd0;
  function automatic logic [7:0] note_mode(input logic [3:0] n);
    return (n >= 4'd1 && n <= NOTE_MAX) ? {4'd0, n} : NOTE_REST;
  endfunction
endpackage

// File: rtl/tone_fifo.sv
// tone_fifo: synchronous FIFO with combinational head, flush and same-cycle push/pop when full
module tone_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16
) (
  input  logic                     clk_62p5mhz,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk_62p5mhz)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk_62p5mhz)
    if (!reset_n || flush) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays queued note/duration entries on the tone generator mode input, with a silent gap after each
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TICK_DIV = 62500,
  parameter int GAP_MS = 5
) (
  input  logic                   clk_62p5mhz,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [15:0]            wr_data,
  input  logic                   enable,
  input  logic                   flush,
  output logic [7:0]             mode,
  output logic                   busy,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state;
  logic [TW-1:0] tick_cnt;
  logic [DUR_W-1:0] ms_cnt;
  logic [7:0] note;
  logic [15:0] head;
  logic pop, wrap, last;
  assign pop = state == LOAD;
  assign wrap = tick_cnt == TW'(TICK_DIV - 1);
  assign last = wrap && ms_cnt == 12'd1;
  assign busy = state != IDLE;
  tone_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk_62p5mhz(clk_62p5mhz),
    .reset_n(reset_n),
    .push(wr_en),
    .pop(pop),
    .flush(flush),
    .din(wr_data),
    .dout(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_62p5mhz)
    if (!reset_n || flush) begin
      state <= IDLE;
      mode <= NOTE_REST;
      note <= NOTE_REST;
      tick_cnt <= '0;
      ms_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          mode <= NOTE_REST;
          if (enable && !empty) state <= LOAD;
        end
        LOAD: begin
          note <= note_mode(head[NOTE_LSB+:NOTE_W]);
          tick_cnt <= '0;
          ms_cnt <= head[DUR_LSB+:DUR_W];
          mode <= head[DUR_LSB+:DUR_W] == '0 ? NOTE_REST : note_mode(head[NOTE_LSB+:NOTE_W]);
          state <= head[DUR_LSB+:DUR_W] == '0 ? IDLE : PLAY;
        end
        PLAY, GAP: begin
          // paused cycles hold both counters and keep the output silent
          mode <= (state == PLAY && enable && !last) ? note : NOTE_REST;
          if (enable) begin
            tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
            ms_cnt <= wrap ? ms_cnt - 1'b1 : ms_cnt;
            if (last) begin
              ms_cnt <= 12'(GAP_MS);
              state <= (state == PLAY && GAP_MS > 0) ? GAP : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table vectors, directed corner sequences and a random run against a countdown reference model
module tb_tone_sequencer;
  localparam int T = 10;
  localparam int GAPN = 5;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic [7:0] mode;
  logic busy, empty, full, overflow;
  logic [4:0] level;
  int total = 0;
  int bad = 0;

  tone_sequencer #(.DEPTH(D), .TICK_DIV(T), .GAP_MS(GAPN)) dut (
    .clk_62p5mhz(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .enable(enable), .flush(flush), .mode(mode), .busy(busy), .empty(empty),
    .full(full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a queue plus a single remaining-cycle countdown per note or gap
  logic [15:0] m_q[$];
  int m_ph = 0, m_rem = 0, m_n;
  logic [7:0] m_nt = 0, m_mm = 0;
  logic m_ovf = 0, m_pop;
  logic [15:0] m_e;

  function automatic logic [7:0] ref_map(input logic [3:0] c);
    return (c >= 1 && c <= 13) ? {4'd0, c} : 8'd0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n || flush) begin
      m_q.delete();
      m_ph = 0; m_mm = 0; m_ovf = 0; m_rem = 0;
    end else begin
      m_pop = m_ph == 1;
      m_n = m_q.size();
      if (m_ph == 0) begin
        m_mm = 0;
        if (enable && m_n > 0) m_ph = 1;
      end else if (m_ph == 1) begin
        m_e = m_q.pop_front();
        if (m_e[15:4] == 0) m_ph = 0;
        else begin
          m_nt = ref_map(m_e[3:0]); m_mm = m_nt; m_rem = int'(m_e[15:4]) * T; m_ph = 2;
        end
      end else if (!enable) m_mm = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_mm = 0;
          if (m_ph == 2 && GAPN > 0) begin m_ph = 3; m_rem = GAPN * T; end
          else m_ph = 0;
        end else m_mm = (m_ph == 2) ? m_nt : 8'd0;
      end
      if (wr_en) begin
        if (m_n < D || m_pop) m_q.push_back(wr_data);
        else m_ovf = 1;
      end
    end
    #1;
    chk("model", 32'({mode, busy, empty, full, level, overflow}),
        32'({m_mm, m_ph != 0, m_q.size() == 0, m_q.size() == D, 5'(m_q.size()), m_ovf}));
  end

  typedef struct {
    logic [3:0] note;
    logic [11:0] dur;
    logic [7:0] exp_mode;
    int exp_first;
    int exp_on;
    int exp_busy;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clean();
    flush = 1'b1; wr_en = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int on, bsy, first, badv, pbad;
    vecs[0] = '{4'd10, 12'd3, 8'd10, 2, 30, 81};
    vecs[1] = '{4'd1, 12'd1, 8'd1, 2, 10, 61};
    vecs[2] = '{4'd13, 12'd2, 8'd13, 2, 20, 71};
    vecs[3] = '{4'd15, 12'd2, 8'd0, -1, 0, 71};
    vecs[4] = '{4'd0, 12'd1, 8'd0, -1, 0, 61};
    vecs[5] = '{4'd14, 12'd1, 8'd0, -1, 0, 61};
    vecs[6] = '{4'd7, 12'd0, 8'd0, -1, 0, 1};
    tick(); tick();
    chk("rst_mode", 32'(mode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      clean();
      enable = 1'b1;
      push({vecs[i].dur, vecs[i].note});
      on = 0; bsy = 0; first = -1; badv = 0;
      for (int k = 1; k <= 120; k++) begin
        tick();
        if (mode != 0) begin
          on++;
          if (first < 0) first = k;
          if (mode != vecs[i].exp_mode) badv++;
        end
        if (busy) bsy++;
      end
      chk($sformatf("vec%0d_first", i), 32'(first), 32'(vecs[i].exp_first));
      chk($sformatf("vec%0d_on", i), 32'(on), 32'(vecs[i].exp_on));
      chk($sformatf("vec%0d_busy", i), 32'(bsy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_val", i), 32'(badv), 0);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 1);
    end

    // overflow: 16 zero-duration entries fill the queue, a 17th audible entry is dropped
    clean();
    enable = 1'b0;
    for (int i = 0; i < 17; i++) push(i < 16 ? 16'h0001 : {12'd1, 4'd13});
    chk("ovf_level", 32'(level), 16);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    enable = 1'b1;
    on = 0;
    for (int k = 0; k < 120; k++) begin tick(); if (mode != 0) on++; end
    chk("ovf_17th_absent", 32'(on), 0);
    chk("ovf_drained", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clean();
    chk("ovf_flush_flag", 32'(overflow), 0);
    chk("ovf_flush_level", 32'(level), 0);

    // flush in the middle of a note, with a same-cycle push
    clean();
    enable = 1'b1;
    push({12'd4, 4'd5});
    push({12'd1, 4'd1}); push({12'd1, 4'd2}); push({12'd1, 4'd3});
    repeat (9) tick();
    chk("fl_pre_mode", 32'(mode), 5);
    chk("fl_pre_level", 32'(level), 3);
    flush = 1'b1; wr_en = 1'b1; wr_data = {12'd2, 4'd9};
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("fl_mode", 32'(mode), 0);
    chk("fl_busy", 32'(busy), 0);
    chk("fl_level", 32'(level), 0);
    repeat (5) tick();
    chk("fl_push_dropped", 32'(level), 0);
    chk("fl_idle", 32'(busy), 0);

    // pause for 40 edges after 12 PLAY cycles
    clean();
    enable = 1'b1;
    push({12'd3, 4'd8});
    on = 0; pbad = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (mode != 0) on++;
      if (k >= 15 && k <= 54 && mode != 0) pbad++;
      if (k == 14) chk("pz_before", 32'(mode), 8);
      if (k == 55) chk("pz_resume", 32'(mode), 8);
      if (k == 14) enable = 1'b0;
      if (k == 54) enable = 1'b1;
    end
    chk("pz_silent", 32'(pbad), 0);
    chk("pz_total", 32'(on), 30);

    // zero-duration entry, rest entry, then a short note
    clean();
    enable = 1'b0;
    push({12'd0, 4'd3}); push({12'd2, 4'd15}); push({12'd1, 4'd5});
    enable = 1'b1;
    on = 0; first = -1; badv = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (mode != 0) begin
        on++;
        if (first < 0) first = k;
        if (mode != 5) badv++;
      end
      if (k == 2) chk("zr_idle_after_zero", 32'(busy), 0);
      if (k == 10) chk("zr_rest_busy", 32'({busy, mode}), 32'h100);
    end
    chk("zr_first", 32'(first), 76);
    chk("zr_on", 32'(on), 10);
    chk("zr_val", 32'(badv), 0);

    // synchronous reset during playback with a full, overflowed queue
    clean();
    enable = 1'b0;
    for (int i = 0; i < 17; i++) push({12'd3, 4'd2});
    enable = 1'b1;
    repeat (10) tick();
    chk("rs_pre_mode", 32'(mode), 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rs_mode", 32'(mode), 0);
    chk("rs_level", 32'(level), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_ovf", 32'(overflow), 0);
    on = 0;
    for (int k = 0; k < 60; k++) begin tick(); if (busy || mode != 0) on++; end
    chk("rs_no_play", 32'(on), 0);

    // random traffic, checked cycle by cycle by the model
    for (int k = 0; k < 3000; k++) begin
      wr_en = $urandom_range(0, 3) == 0;
      wr_data = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      enable = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 199) == 0;
      reset_n = $urandom_range(0, 499) != 0;
      tick();
    end
    wr_en = 1'b0; flush = 1'b0; reset_n = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
